// File: rtl/sram_pkg.sv
// Shared defaults and geometry helpers for the banked 1RW+1R SRAM.
package sram_pkg;

    localparam int TILE_DW_DEF = 8;
    localparam int TILE_AW_DEF = 10;

    function automatic int calc_cols(input int data_width, input int tile_dw);
        return data_width / tile_dw;
    endfunction

    function automatic int calc_rows(input int addr_width, input int tile_aw);
        return 1 << (addr_width - tile_aw);
    endfunction

    function automatic int calc_mask_w(input int data_width, input int tile_dw);
        return data_width / tile_dw;
    endfunction

endpackage

// File: rtl/sram_tile.sv
// One 8x1024 1rw1r tile: the sky130 hard macro, or a synchronous-read model.
module sram_tile
    import sram_pkg::*;
#(
    parameter int DW = TILE_DW_DEF,
    parameter int AW = TILE_AW_DEF
) (
    input  logic          clk_i,
    input  logic          csb0_i,
    input  logic          web0_i,
    input  logic          wmask0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] din0_i,
    output logic [DW-1:0] dout0_o,
    input  logic          csb1_i,
    input  logic [AW-1:0] addr1_i,
    output logic [DW-1:0] dout1_o
);

`ifdef SKY130
    sky130_sram_1kbyte_1rw1r_8x1024_8 u_macro (
        .clk0   (clk_i),
        .csb0   (csb0_i),
        .web0   (web0_i),
        .wmask0 (wmask0_i),
        .addr0  (addr0_i),
        .din0   (din0_i),
        .dout0  (dout0_o),
        .clk1   (clk_i),
        .csb1   (csb1_i),
        .addr1  (addr1_i),
        .dout1  (dout1_o)
    );
`else
    logic [DW-1:0] mem_q [2**AW];

    // Port-1 read of a word being written this edge returns the old word.
    always_ff @(posedge clk_i) begin
        if (!csb0_i && !web0_i && wmask0_i) mem_q[addr0_i] <= din0_i;
        if (!csb0_i && web0_i)               dout0_o       <= mem_q[addr0_i];
        if (!csb1_i)                         dout1_o       <= mem_q[addr1_i];
    end
`endif

endmodule

// File: rtl/sram_1rw1r_banked.sv
// 1RW+1R memory built from a ROWS x COLS grid of tiles, with registered
// output hold, read-valid strobes and optional write-to-read bypass on port 1.
module sram_1rw1r_banked
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int TILE_DW    = TILE_DW_DEF,
    parameter int TILE_AW    = TILE_AW_DEF,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          p0_en,
    input  logic                          p0_we,
    input  logic [DATA_WIDTH/TILE_DW-1:0] p0_wmask,
    input  logic [ADDR_WIDTH-1:0]         p0_addr,
    input  logic [DATA_WIDTH-1:0]         p0_wdata,
    output logic [DATA_WIDTH-1:0]         p0_rdata,
    output logic                          p0_rvalid,
    input  logic                          p1_en,
    input  logic [ADDR_WIDTH-1:0]         p1_addr,
    output logic [DATA_WIDTH-1:0]         p1_rdata,
    output logic                          p1_rvalid
);

    localparam int COLS = calc_cols(DATA_WIDTH, TILE_DW);
    localparam int ROWS = calc_rows(ADDR_WIDTH, TILE_AW);
    localparam int MW   = calc_mask_w(DATA_WIDTH, TILE_DW);
    localparam int RW   = (ADDR_WIDTH > TILE_AW) ? ADDR_WIDTH - TILE_AW : 1;

    if ((DATA_WIDTH % TILE_DW) != 0 || ADDR_WIDTH < TILE_AW) begin : g_bad_geometry
        $fatal(1, "sram_1rw1r_banked: DATA_WIDTH must be a multiple of TILE_DW and ADDR_WIDTH >= TILE_AW");
    end

    logic [RW-1:0] p0_row, p1_row;

    if (ADDR_WIDTH > TILE_AW) begin : g_row_sel
        assign p0_row = p0_addr[ADDR_WIDTH-1:TILE_AW];
        assign p1_row = p1_addr[ADDR_WIDTH-1:TILE_AW];
    end else begin : g_row_single
        assign p0_row = '0;
        assign p1_row = '0;
    end

    logic [ROWS-1:0][DATA_WIDTH-1:0] p0_dout;
    logic [ROWS-1:0][DATA_WIDTH-1:0] p1_dout;

    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        for (genvar c = 0; c < COLS; c++) begin : g_cols
            sram_tile #(
                .DW (TILE_DW),
                .AW (TILE_AW)
            ) u_tile (
                .clk_i    (clk),
                .csb0_i   (!(p0_en && (p0_row == RW'(r)))),
                .web0_i   (!p0_we),
                .wmask0_i (p0_wmask[c]),
                .addr0_i  (p0_addr[TILE_AW-1:0]),
                .din0_i   (p0_wdata[c*TILE_DW +: TILE_DW]),
                .dout0_o  (p0_dout[r][c*TILE_DW +: TILE_DW]),
                .csb1_i   (!(p1_en && (p1_row == RW'(r)))),
                .addr1_i  (p1_addr[TILE_AW-1:0]),
                .dout1_o  (p1_dout[r][c*TILE_DW +: TILE_DW])
            );
        end
    end

    // Stage 1: tiles are reading; remember which row and whether a collision occurred.
    logic                  p0_rd_q, p1_rd_q, coll_q;
    logic [RW-1:0]         p0_row_q, p1_row_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [MW-1:0]         byp_mask_q;
    logic                  p0_rd_d, p1_rd_d, coll_d;

    assign p0_rd_d = p0_en && !p0_we;
    assign p1_rd_d = p1_en;
    assign coll_d  = p0_en && p0_we && p1_en && (p0_addr == p1_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rd_q    <= 1'b0;
            p1_rd_q    <= 1'b0;
            coll_q     <= 1'b0;
            p0_row_q   <= '0;
            p1_row_q   <= '0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else begin
            p0_rd_q    <= p0_rd_d;
            p1_rd_q    <= p1_rd_d;
            coll_q     <= coll_d;
            p0_row_q   <= p0_row;
            p1_row_q   <= p1_row;
            byp_data_q <= p0_wdata;
            byp_mask_q <= p0_wmask;
        end
    end

    logic [DATA_WIDTH-1:0] p1_merged;

    always_comb begin
        p1_merged = p1_dout[p1_row_q];
        for (int i = 0; i < COLS; i++) begin
            if (BYPASS && coll_q && byp_mask_q[i]) begin
                p1_merged[i*TILE_DW +: TILE_DW] = byp_data_q[i*TILE_DW +: TILE_DW];
            end
        end
    end

    // Stage 2: output registers only load on a completed read, otherwise hold.
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
    logic                  p0_rvalid_q, p1_rvalid_q;

    assign p0_rdata_d = p0_rd_q ? p0_dout[p0_row_q] : p0_rdata_q;
    assign p1_rdata_d = p1_rd_q ? p1_merged         : p1_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rd_q;
            p1_rvalid_q <= p1_rd_q;
        end
    end

    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;

endmodule

// File: tb/tb_sram_1rw1r_banked.sv
// Bench for sram_1rw1r_banked: directed scenarios plus random traffic,
// checked against a reference memory through per-port expected queues.
module tb_sram_1rw1r_banked;

    localparam int DW = 64;
    localparam int AW = 12;
    localparam int MW = 8;
    localparam bit BYPASS = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          p0_en = 1'b0, p0_we = 1'b0, p1_en = 1'b0;
    logic [MW-1:0] p0_wmask = '0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_rvalid, p1_rvalid;

    sram_1rw1r_banked #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TILE_DW    (8),
        .TILE_AW    (10),
        .BYPASS     (BYPASS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_en     (p0_en),
        .p0_we     (p0_we),
        .p0_wmask  (p0_wmask),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rdata  (p0_rdata),
        .p0_rvalid (p0_rvalid),
        .p1_en     (p1_en),
        .p1_addr   (p1_addr),
        .p1_rdata  (p1_rdata),
        .p1_rvalid (p1_rvalid)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    logic [DW-1:0] hold0 = '0, hold1 = '0;

    // Expected strobe timing: request sampled at edge N, pulse after edge N+1.
    logic v0_s1 = 1'b0, v0_s2 = 1'b0, v1_s1 = 1'b0, v1_s2 = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_s1 <= 1'b0; v0_s2 <= 1'b0; v1_s1 <= 1'b0; v1_s2 <= 1'b0;
        end else begin
            v0_s1 <= p0_en && !p0_we;
            v0_s2 <= v0_s1;
            v1_s1 <= p1_en;
            v1_s2 <= v1_s1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Every cycle: strobe must match the expected timing, rdata must equal
    // the latest expected read value (so holding is checked too).
    always @(negedge clk) begin
        chk("p0_rvalid", p0_rvalid, v0_s2);
        chk("p1_rvalid", p1_rvalid, v1_s2);
        if (v0_s2) begin
            chk("p0_exp_avail", exp0_q.size() != 0, 1'b1);
            if (exp0_q.size() != 0) hold0 = exp0_q.pop_front();
        end
        if (v1_s2) begin
            chk("p1_exp_avail", exp1_q.size() != 0, 1'b1);
            if (exp1_q.size() != 0) hold1 = exp1_q.pop_front();
        end
        chk("p0_rdata", p0_rdata, hold0);
        chk("p1_rdata", p1_rdata, hold1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic e0, input logic we0, input logic [MW-1:0] m0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1);
        logic [DW-1:0] v;
        @(negedge clk);
        p0_en = e0; p0_we = we0; p0_wmask = m0; p0_addr = a0; p0_wdata = d0;
        p1_en = e1; p1_addr = a1;
        if (e0 && !we0) exp0_q.push_back(ref_mem[a0]);
        if (e1) begin
            v = ref_mem[a1];
            if (BYPASS && e0 && we0 && (a0 == a1)) begin
                for (int i = 0; i < MW; i++)
                    if (m0[i]) v[i*8 +: 8] = d0[i*8 +: 8];
            end
            exp1_q.push_back(v);
        end
        if (e0 && we0) begin
            for (int i = 0; i < MW; i++)
                if (m0[i]) ref_mem[a0][i*8 +: 8] = d0[i*8 +: 8];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        drive(1'b1, 1'b1, m, a, d, 1'b0, '0);
    endtask

    task automatic rd0(input logic [AW-1:0] a);
        drive(1'b1, 1'b0, '0, a, '0, 1'b0, '0);
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    // Read in flight when reset hits must be discarded.
    task automatic reset_mid(input logic [AW-1:0] a);
        rd1(a);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        p0_en = 1'b0; p0_we = 1'b0; p1_en = 1'b0;
        exp0_q.delete(); exp1_q.delete();
        hold0 = '0; hold1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [AW-1:0] pool [5];

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        pool[0] = 12'h010; pool[1] = 12'h011; pool[2] = 12'h410;
        pool[3] = 12'h810; pool[4] = 12'hC10;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        rd1(12'h000);                                  // uninitialised read
        idle(2);

        wr0(12'h123, 64'h0123456789ABCDEF, 8'hFF);     // full write, read back
        rd0(12'h123);
        idle(2);

        wr0(12'h123, 64'hFFFFFFFFFFFFFFFF, 8'h0F);     // partial write
        rd1(12'h123);
        idle(2);

        wr0(12'h123, 64'h0, 8'h00);                    // empty mask is a no-op
        drive(1'b1, 1'b0, '0, 12'h123, '0, 1'b1, 12'h123);
        idle(2);

        wr0(12'h800, 64'h1111111111111111, 8'hFF);     // same-edge collision
        drive(1'b1, 1'b1, 8'hF0, 12'h800, 64'hAAAAAAAAAAAAAAAA, 1'b1, 12'h800);
        rd0(12'h800);
        idle(2);

        wr0(12'h3FF, 64'd5, 8'hFF);                    // row boundary and hold
        wr0(12'h400, 64'd7, 8'hFF);
        rd0(12'h3FF);
        idle(3);
        rd0(12'h400);
        wr0(12'h400, 64'hDEAD, 8'hFF);                 // writes leave rdata held
        idle(2);

        for (int i = 0; i < 6; i++)                    // back-to-back on both ports
            drive(1'b1, 1'b0, '0, (i % 2) ? 12'h3FF : 12'h400, '0,
                  1'b1, (i % 2) ? 12'h400 : 12'h3FF);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            logic [MW-1:0] m;
            m = MW'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) m = '0;
            if ($urandom_range(0, 7) == 1) m = '1;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m,
                  pool[$urandom_range(0, 4)], {$urandom, $urandom},
                  1'($urandom_range(0, 1)), pool[$urandom_range(0, 4)]);
        end
        idle(3);

        rd0(12'h123);                                  // make held data nonzero
        idle(2);
        reset_mid(12'h123);
        idle(3);
        rd0(12'h800);
        rd1(12'h400);
        idle(3);

        chk("p0_drained", DW'(exp0_q.size()), '0);
        chk("p1_drained", DW'(exp1_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
